// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and tag sizing.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Source tag needs at least one bit even for a degenerate single-producer build
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] sel_o,
    output logic           any_o
);

    logic [N-1:0] rot;

    // Rotate so the slot after ptr_i lands at bit 0, pick the lowest set bit, rotate back
    always_comb begin
        automatic int start = (int'(ptr_i) + 1) % N;
        automatic int idx   = 0;
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req_i[(start + i) % N];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) idx = i;
        end
        any_o = |req_i;
        sel_o = IDW'((start + idx) % N);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with packet lock in front of a single FIFO write port;
// each written word carries the winning producer's index in its MSBs.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int Width     = 16,
    parameter  int MAX_BURST = 8,
    localparam int ID_W      = tag_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       last,
    input  logic [NUM_REQ*Width-1:0] wdata,
    output logic [NUM_REQ-1:0]       ack,
    input  logic                     fifo_full,
    output logic                     fifo_w_en,
    output logic [ID_W+Width-1:0]    fifo_wdata,
    output logic [ID_W-1:0]          owner,
    output logic                     locked
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]   pick_sel;
    logic              pick_any;
    logic [ID_W-1:0]   sel;
    logic              sel_req;
    logic              accept;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .sel_o (pick_sel),
        .any_o (pick_any)
    );

    // While locked only the owner may write, even if it is bubbling and others are waiting
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;

        if (state_q == ST_LOCKED) begin
            sel     = owner_q;
            sel_req = req[owner_q];
        end else begin
            sel     = pick_sel;
            sel_req = pick_any;
        end

        // Gating with rst keeps the write strobe quiet while reset is held
        accept     = rst & sel_req & ~fifo_full;
        ack        = '0;
        ack[sel]   = accept;
        fifo_w_en  = accept;
        fifo_wdata = {sel, wdata[int'(sel)*Width +: Width]};

        if (accept) begin
            if (state_q == ST_IDLE) begin
                owner_d = sel;
                if (last[sel] || MAX_BURST == 1) begin
                    rr_ptr_d = sel;
                end else begin
                    state_d    = ST_LOCKED;
                    beat_cnt_d = CNT_W'(1);
                end
            end else begin
                if (last[owner_q] || (beat_cnt_q + 1'b1) == CNT_W'(MAX_BURST)) begin
                    state_d    = ST_IDLE;
                    rr_ptr_d   = owner_q;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
        end
    end

    // Pointer resets to the last slot so producer 0 is scanned first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= ID_W'(NUM_REQ - 1);
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign owner  = owner_q;
    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed packet scenarios with hand-computed
// expected FIFO words, then a randomized phase checking ordering, exclusivity and fairness.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int MB   = 4;

    logic        clk;
    logic        rstN;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [63:0] wdata;
    logic [3:0]  ack;
    logic        fifoFull;
    logic        fifoWEn;
    logic [17:0] fifoWData;
    logic [1:0]  owner;
    logic        locked;

    int total = 0;
    int bad   = 0;

    logic [17:0] expQ[$];
    logic [3:0]  active;
    int          left[4];
    logic [7:0]  dataCnt[4];
    logic [7:0]  seen[4];
    int          waitBeats[4];
    bit          randMode = 0;

    logic [3:0]  sAck;
    logic        sWEn;
    logic        sLocked;
    logic [1:0]  sOwner;

    logic [1:0]  monId;
    logic [17:0] monExp;

    fifo_wr_arbiter #(
        .NUM_REQ   (NREQ),
        .Width     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .rst        (rstN),
        .req        (req),
        .last       (last),
        .wdata      (wdata),
        .ack        (ack),
        .fifo_full  (fifoFull),
        .fifo_w_en  (fifoWEn),
        .fifo_wdata (fifoWData),
        .owner      (owner),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int id, input logic [15:0] data);
        expQ.push_back({id[1:0], data});
    endtask

    task automatic startPkt(input int id, input int len);
        active[id] = 1'b1;
        left[id]   = len;
    endtask

    // Producers drive {id, running beat count}; they advance only on their own ack
    task automatic applyStimulus(input logic full, input logic [3:0] bubble);
        fifoFull = full;
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = active[i] & ~bubble[i];
            last[i]            = (left[i] == 1);
            wdata[i*W +: W]    = {8'(i), dataCnt[i]};
        end
        @(negedge clk);
        #1;
        sAck    = ack;
        sWEn    = fifoWEn;
        sLocked = locked;
        sOwner  = owner;
        for (int i = 0; i < NREQ; i++) begin
            if (randMode) begin
                if (req[i] && !sAck[i] && sWEn) begin
                    waitBeats[i]++;
                    checkOutput("starve", 32'(waitBeats[i] > NREQ * MB), 0);
                end else if (!req[i] || sAck[i]) begin
                    waitBeats[i] = 0;
                end
            end
            if (sAck[i]) begin
                dataCnt[i]++;
                left[i]--;
                if (left[i] == 0) active[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every write the DUT presents
    always @(negedge clk) begin
        if (rstN) begin
            checkOutput("ack_onehot0", 32'($onehot0(ack)), 1);
            checkOutput("wen_while_full", 32'(fifoWEn & fifoFull), 0);
            checkOutput("ack_vs_wen", 32'(|ack), 32'(fifoWEn));
            if (fifoWEn) begin
                monId = fifoWData[17:16];
                if (randMode) begin
                    checkOutput("tag_id", 32'(fifoWData[15:8]), 32'(monId));
                    checkOutput("order", 32'(fifoWData[7:0]), 32'(seen[monId]));
                    checkOutput("ack_id", 32'(ack), 32'(4'b0001 << monId));
                    seen[monId]++;
                end else if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got %0h expected none", fifoWData);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("wdata", 32'(fifoWData), 32'(monExp));
                    checkOutput("ack", 32'(ack), 32'(4'b0001 << monExp[17:16]));
                end
            end
        end
    end

    initial begin
        rstN     = 1'b0;
        req      = 4'hF;
        last     = 4'hF;
        wdata    = '0;
        fifoFull = 1'b0;
        active   = '0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0; dataCnt[i] = '0; seen[i] = '0; waitBeats[i] = 0;
        end

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("rst_wen", 32'(fifoWEn), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_owner", 32'(owner), 0);
        rstN = 1'b1;
        req  = '0;
        last = '0;
        @(posedge clk);
        #1;

        // All four single-beat producers: strict rotation from producer 0
        for (int i = 0; i < NREQ; i++) begin
            pushExp(i, {8'(i), 8'h00});
            startPkt(i, 1);
        end
        for (int k = 0; k < NREQ; k++) begin
            applyStimulus(1'b0, 4'b0000);
            checkOutput("s1_ack", 32'(sAck), 32'(4'b0001 << k));
            checkOutput("s1_locked", 32'(sLocked), 0);
        end
        checkOutput("s1_drain", 32'(expQ.size()), 0);

        // Five-beat packet on id 2 is cut after MAX_BURST, id 0 slips in, then the tail
        pushExp(2, 16'h0201); pushExp(2, 16'h0202); pushExp(2, 16'h0203); pushExp(2, 16'h0204);
        pushExp(0, 16'h0001); pushExp(2, 16'h0205);
        startPkt(2, 5);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s2_first_locked", 32'(sLocked), 0);
        startPkt(0, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 4'b0000);
            checkOutput("s2_locked", 32'(sLocked), 1);
            checkOutput("s2_owner", 32'(sOwner), 2);
            checkOutput("s2_ack", 32'(sAck), 32'(4'b0100));
        end
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s2_release", 32'(sLocked), 0);
        checkOutput("s2_ack_p0", 32'(sAck), 32'(4'b0001));
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s2_ack_tail", 32'(sAck), 32'(4'b0100));
        checkOutput("s2_drain", 32'(expQ.size()), 0);

        // Three-beat packet on id 1 with a three-cycle full stall after beat 1
        pushExp(1, 16'h0101); pushExp(1, 16'h0102); pushExp(1, 16'h0103);
        startPkt(1, 3);
        applyStimulus(1'b0, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'b0000);
            checkOutput("s3_wen", 32'(sWEn), 0);
            checkOutput("s3_ack", 32'(sAck), 0);
            checkOutput("s3_owner", 32'(sOwner), 1);
            checkOutput("s3_locked", 32'(sLocked), 1);
        end
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s3_idle_after", 32'(sLocked), 0);
        checkOutput("s3_drain", 32'(expQ.size()), 0);

        // Owner 3 bubbles for two cycles while id 0 waits; lock must hold
        pushExp(3, 16'h0301); pushExp(3, 16'h0302); pushExp(3, 16'h0303); pushExp(0, 16'h0002);
        startPkt(3, 3);
        applyStimulus(1'b0, 4'b0000);
        startPkt(0, 1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 4'b1000);
            checkOutput("s4_ack", 32'(sAck), 0);
            checkOutput("s4_locked", 32'(sLocked), 1);
            checkOutput("s4_owner", 32'(sOwner), 3);
        end
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s4_ack_p0", 32'(sAck), 32'(4'b0001));
        checkOutput("s4_drain", 32'(expQ.size()), 0);

        // Reset asserted while id 1 is locked after two beats
        pushExp(1, 16'h0104); pushExp(1, 16'h0105);
        startPkt(1, 4);
        applyStimulus(1'b0, 4'b0000);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s5_locked_pre", 32'(sLocked), 1);
        rstN = 1'b0;
        #1;
        checkOutput("s5_rst_locked", 32'(locked), 0);
        checkOutput("s5_rst_ack", 32'(ack), 0);
        checkOutput("s5_rst_wen", 32'(fifoWEn), 0);
        checkOutput("s5_drain_pre", 32'(expQ.size()), 0);
        active = '0;
        req    = '0;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        pushExp(0, 16'h0003); pushExp(1, 16'h0106); pushExp(2, 16'h0206); pushExp(3, 16'h0304);
        for (int i = 0; i < NREQ; i++) startPkt(i, 1);
        applyStimulus(1'b0, 4'b0000);
        checkOutput("s5_first_ack", 32'(sAck), 32'(4'b0001));
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 4'b0000);
        checkOutput("s5_drain", 32'(expQ.size()), 0);

        // Randomized traffic with bubbles and backpressure
        for (int i = 0; i < NREQ; i++) begin
            seen[i]      = dataCnt[i];
            waitBeats[i] = 0;
        end
        randMode = 1;
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] bub;
            for (int i = 0; i < NREQ; i++) begin
                if (!active[i] && ($urandom % 4) == 0) startPkt(i, 1 + int'($urandom % 6));
                bub[i] = (($urandom % 8) == 0);
            end
            applyStimulus(($urandom % 4) == 0, bub);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
